// File: rtl/inf_Master.sv
`default_nettype none
// ============================================================================
// Package  : inf_Master
// Brief    : Master-side AXI bundles. M2AXIout carries everything a master
//            drives (AR, R-ready, AW, W, B-ready); M2AXIin carries everything
//            it receives (AR-ready, R, AW-ready, W-ready, B).
// Revision : 1.0 - initial release
// ============================================================================
package inf_Master;

  typedef struct packed {
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid;
    logic        rready;
    logic [3:0]  awid;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic        awvalid;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        bready;
  } M2AXIout;

  typedef struct packed {
    logic        arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        awready;
    logic        wready;
    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid;
  } M2AXIin;

endpackage

`default_nettype wire

// File: rtl/dma_engine.sv
`default_nettype none
// ============================================================================
// Module   : dma_engine
// Brief    : AXI master data mover. Copies data_qty_i words from src to dst
//            as alternating read/write INCR bursts through a local buffer,
//            never crossing a 4 KB boundary, then pulses dma_fin_o.
// Revision : 1.0 - initial release
// ============================================================================
module dma_engine #(
  parameter logic [3:0] AXI_ID    = 4'h0,
  parameter int         MAX_BURST = 16
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                dma_en_i,
  input  logic [31:0]         src_addr_i,
  input  logic [31:0]         dst_addr_i,
  input  logic [31:0]         data_qty_i,
  output logic                dma_fin_o,
  output logic                dma_busy_o,
  output logic                dma_err_o,
  output inf_Master::M2AXIout m2axi_o,
  input  inf_Master::M2AXIin  m2axi_i
);

  // Buffer index width; the buffer only ever holds one burst.
  localparam int         c_PW         = (MAX_BURST > 2) ? $clog2(MAX_BURST) : 1;
  localparam int         c_DEPTH      = 1 << c_PW;
  localparam logic [1:0] c_RESP_OKAY  = 2'b00;
  localparam logic [1:0] c_BURST_INCR = 2'b01;
  localparam logic [2:0] c_SIZE_WORD  = 3'b010;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RD_AR = 3'd1,
    S_RD_R  = 3'd2,
    S_WR_AW = 3'd3,
    S_WR_W  = 3'd4,
    S_WR_B  = 3'd5,
    S_DONE  = 3'd6
  } state_t;

  state_t      r_state;
  state_t      w_state_next;

  logic [31:0] r_src;
  logic [31:0] r_dst;
  logic [31:0] r_rem;
  logic [4:0]  r_blen;
  logic [3:0]  r_wptr;
  logic [3:0]  r_rptr;
  logic        r_err;
  logic [31:0] r_buf [c_DEPTH];

  logic        w_start;
  logic        w_r_hs;
  logic        w_w_hs;
  logic        w_b_hs;
  logic        w_wlast;
  logic [4:0]  w_len_m1;
  logic [31:0] w_src_inc;
  logic [31:0] w_dst_inc;
  logic [31:0] w_rem_dec;
  logic        w_unused;

  // Burst length: remaining words, clipped to the buffer depth and to the
  // words left before the next 4 KB boundary on either side.
  function automatic logic [4:0] f_blen(input logic [31:0] rem,
                                        input logic [9:0]  src_w,
                                        input logic [9:0]  dst_w);
    logic [31:0] v;
    logic [31:0] src_room;
    logic [31:0] dst_room;
    v        = rem;
    src_room = 32'd1024 - {22'd0, src_w};
    dst_room = 32'd1024 - {22'd0, dst_w};
    if (v > 32'(MAX_BURST)) v = 32'(MAX_BURST);
    if (v > src_room)       v = src_room;
    if (v > dst_room)       v = dst_room;
    return 5'(v);
  endfunction

  assign w_start   = (r_state == S_IDLE) && dma_en_i;
  assign w_r_hs    = (r_state == S_RD_R) && m2axi_i.rvalid;
  assign w_w_hs    = (r_state == S_WR_W) && m2axi_i.wready;
  assign w_b_hs    = (r_state == S_WR_B) && m2axi_i.bvalid;
  assign w_len_m1  = r_blen - 5'd1;
  assign w_wlast   = ({1'b0, r_rptr} == w_len_m1);
  assign w_src_inc = r_src + {25'd0, r_blen, 2'b00};
  assign w_dst_inc = r_dst + {25'd0, r_blen, 2'b00};
  assign w_rem_dec = r_rem - {27'd0, r_blen};

  // Byte-lane bits of the addresses and the AXI IDs are intentionally ignored.
  assign w_unused = &{1'b0, src_addr_i[1:0], dst_addr_i[1:0],
                      m2axi_i.rid, m2axi_i.bid};

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state decode; each phase advances only on its own handshake.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (dma_en_i) begin
          w_state_next = (data_qty_i == 32'd0) ? S_DONE : S_RD_AR;
        end
      end
      S_RD_AR: if (m2axi_i.arready)                   w_state_next = S_RD_R;
      S_RD_R:  if (m2axi_i.rvalid && m2axi_i.rlast)   w_state_next = S_WR_AW;
      S_WR_AW: if (m2axi_i.awready)                   w_state_next = S_WR_W;
      S_WR_W:  if (m2axi_i.wready && w_wlast)         w_state_next = S_WR_B;
      S_WR_B: begin
        if (m2axi_i.bvalid) begin
          w_state_next = (w_rem_dec == 32'd0) ? S_DONE : S_RD_AR;
        end
      end
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Transfer bookkeeping: addresses, remaining count, burst length,
  // buffer pointers and the sticky error flag.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_src  <= '0;
      r_dst  <= '0;
      r_rem  <= '0;
      r_blen <= '0;
      r_wptr <= '0;
      r_rptr <= '0;
      r_err  <= 1'b0;
    end else begin
      if (w_start) begin
        r_src  <= {src_addr_i[31:2], 2'b00};
        r_dst  <= {dst_addr_i[31:2], 2'b00};
        r_rem  <= data_qty_i;
        r_blen <= f_blen(data_qty_i, src_addr_i[11:2], dst_addr_i[11:2]);
        r_wptr <= '0;
        r_rptr <= '0;
        r_err  <= 1'b0;
      end
      if (w_r_hs) begin
        r_wptr <= r_wptr + 4'd1;
        if (m2axi_i.rresp != c_RESP_OKAY) r_err <= 1'b1;
      end
      if (w_w_hs) begin
        r_rptr <= r_rptr + 4'd1;
      end
      if (w_b_hs) begin
        r_src <= w_src_inc;
        r_dst <= w_dst_inc;
        r_rem <= w_rem_dec;
        if (m2axi_i.bresp != c_RESP_OKAY) r_err <= 1'b1;
        // Next burst is sized from the advanced addresses before RD_AR.
        if (w_rem_dec != 32'd0) begin
          r_blen <= f_blen(w_rem_dec, w_src_inc[11:2], w_dst_inc[11:2]);
          r_wptr <= '0;
          r_rptr <= '0;
        end
      end
    end
  end

  // Burst buffer; contents need no reset since every read follows a fill.
  always_ff @(posedge clk) begin
    if (w_r_hs) begin
      r_buf[r_wptr[c_PW-1:0]] <= m2axi_i.rdata;
    end
  end

  // Moore AXI outputs: handshake strobes decode from state only, payload
  // comes straight from registers so it is stable while VALID is high.
  always_comb begin
    m2axi_o         = '0;
    m2axi_o.arid    = AXI_ID;
    m2axi_o.araddr  = r_src;
    m2axi_o.arlen   = {3'd0, w_len_m1};
    m2axi_o.arsize  = c_SIZE_WORD;
    m2axi_o.arburst = c_BURST_INCR;
    m2axi_o.awid    = AXI_ID;
    m2axi_o.awaddr  = r_dst;
    m2axi_o.awlen   = {3'd0, w_len_m1};
    m2axi_o.awsize  = c_SIZE_WORD;
    m2axi_o.awburst = c_BURST_INCR;
    m2axi_o.wdata   = r_buf[r_rptr[c_PW-1:0]];
    m2axi_o.wstrb   = 4'hF;
    m2axi_o.wlast   = (r_state == S_WR_W) && w_wlast;
    case (r_state)
      S_RD_AR: m2axi_o.arvalid = 1'b1;
      S_RD_R:  m2axi_o.rready  = 1'b1;
      S_WR_AW: m2axi_o.awvalid = 1'b1;
      S_WR_W:  m2axi_o.wvalid  = 1'b1;
      S_WR_B:  m2axi_o.bready  = 1'b1;
      default: ;
    endcase
  end

  assign dma_fin_o  = (r_state == S_DONE);
  assign dma_busy_o = (r_state != S_IDLE);
  assign dma_err_o  = r_err;

endmodule

`default_nettype wire

// File: doc/dma_engine.md
# dma_engine

Data-mover stage that consumes the DMA register slave's outputs. On a start pulse it copies `data_qty_i` 32-bit words from `src_addr_i` to `dst_addr_i` over the system AXI as a master. Each pass issues one INCR read burst into an internal 16-word buffer, then one write burst drained from that buffer. When the last write response returns, the block pulses `dma_fin_o`.

## Interface
- `AXI_ID`, default 4'h0: constant ARID/AWID driven on every burst.
- `MAX_BURST`, default 16: maximum beats per burst and buffer depth in words. Must be a power of two, ≤16.
- `clk` in 1: system clock, rising edge.
- `rstn` in 1: asynchronous, active-low reset.
- `dma_en_i` in 1: start pulse, one cycle.
- `src_addr_i` in 32: source byte address. Bits [1:0] are ignored.
- `dst_addr_i` in 32: destination byte address. Bits [1:0] are ignored.
- `data_qty_i` in 32: transfer length in words.
- `dma_fin_o` out 1: one-cycle completion pulse.
- `dma_busy_o` out 1: high from the cycle after start until `dma_fin_o`, inclusive.
- `dma_err_o` out 1: sticky error. Set by any non-OKAY RRESP/BRESP; cleared on the next accepted start.
- `m2axi_o` out bundle `inf_Master.M2AXIout`: AR, R-ready, AW, W and B-ready fields.
- `m2axi_i` in bundle `inf_Master.M2AXIin`: ARREADY, R, AWREADY, WREADY and B fields.

## Operation
- **States:** IDLE, RD_AR, RD_R, WR_AW, WR_W, WR_B, DONE.
- **Start (IDLE):** on `dma_en_i` the block latches `src` = {src_addr_i[31:2],2'b00}, `dst` likewise, and `rem` = `data_qty_i`.
  - If `data_qty_i` == 0, go to DONE and generate no AXI traffic.
  - Otherwise go to RD_AR.
- **Start while busy:** `dma_en_i` outside IDLE is ignored and the latched values are unchanged.
- **Burst length:** `blen` = min(`rem`, MAX_BURST, 1024 − src[11:2], 1024 − dst[11:2]). No burst crosses a 4 KB boundary on either side. `blen` is computed on entry to RD_AR and held through WR_B.
- **RD_AR:**
  - ARVALID=1, ARADDR=`src`, ARLEN=`blen`−1, ARSIZE=3'b010, ARBURST=INCR, ARID=`AXI_ID`.
  - On ARVALID&ARREADY go to RD_R.
- **RD_R:**
  - RREADY=1. Each R handshake writes RDATA to `buf[wptr]` and increments `wptr`.
  - A non-OKAY RRESP sets `dma_err_o`.
  - On the RLAST handshake go to WR_AW.
  - Beat counting uses RLAST only. If a slave returns fewer beats than `blen` with RLAST, the write still sends exactly `blen` beats.
- **WR_AW:**
  - AWVALID=1, AWADDR=`dst`, AWLEN=`blen`−1, AWSIZE=3'b010, AWBURST=INCR, AWID=`AXI_ID`.
  - On the AW handshake go to WR_W.
- **WR_W:**
  - WVALID=1, WDATA=`buf[rptr]`, WSTRB=4'hF, WLAST=1 when the beat count equals `blen`−1.
  - Each W handshake increments `rptr`. On the WLAST handshake go to WR_B.
- **WR_B:**
  - BREADY=1. On the B handshake: set `dma_err_o` if BRESP ≠ OKAY.
  - Update `src` += `blen`·4, `dst` += `blen`·4, `rem` −= `blen`.
  - If the new `rem` == 0, go to DONE; else go to RD_AR.
- **DONE:** `dma_fin_o`=1 for exactly one cycle, then IDLE.
- **Buffer pointers:** `wptr` and `rptr` are 4-bit and reset to 0 at each RD_AR entry. The buffer never holds more than one burst, so full/empty flags are unnecessary.
- **Errors:** an error never aborts the transfer; the full length is always moved.
- **Address wrap:** `src`/`dst` increments wrap modulo 2^32 with no special handling.
- **Channel ordering:** read and write channels are never active at the same time. AR and AW are never both valid.

## Timing
- **Reset values** (asynchronous on `rstn` low, including mid-burst):
  - State = IDLE; all VALID/READY outputs = 0; `dma_fin_o`, `dma_busy_o`, `dma_err_o` = 0.
  - Latched `src`, `dst`, `rem`, `blen`, pointers = 0. Buffer contents are don't-care.
- **Output drive:** all AXI control outputs are decoded from state (Moore). ARVALID/AWVALID/WVALID assert the cycle after the state is entered and stay stable until the handshake. ADDR/LEN/DATA are stable while VALID is high.
- **Start to AR:** `dma_en_i` at cycle T gives ARVALID at T+1.
- **Last B to fin:** last B handshake at cycle T gives `dma_fin_o` at T+1.
- **Zero-length:** `data_qty_i`=0 gives `dma_fin_o` at T+1 with no VALID asserted.
- **Throughput:** one beat per cycle under zero back-pressure. Per burst overhead is 1 AR + 1 AW + 1 B cycle minimum.
- **RLAST with AR:** RLAST arriving in the same cycle as any other event is impossible, because the channels are exclusive.

## Test plan
- **Single word:** src=0x1000, dst=0x2000, qty=1, memory[0x1000]=0xDEADBEEF. Expect one ARLEN=0 burst, one AWLEN=0 burst, write 0xDEADBEEF to 0x2000, `dma_fin_o` one cycle after B, `dma_err_o`=0.
- **Multi-burst:** qty=40, src=0x0, dst=0x8000. Expect bursts with ARLEN/AWLEN 15,15,7 at src 0x0/0x40/0x80. Destination equals source word-for-word.
- **4 KB split:** src=0x0FF8, dst=0x3000, qty=8. Expect a first burst of 2 beats (to 0x1000), then 6 beats at src 0x1000/dst 0x3008.
- **Zero length:** qty=0. Expect `dma_fin_o` at T+1 and no ARVALID/AWVALID ever.
- **Back-pressure and errors:**
  - Random ARREADY/RVALID/AWREADY/WREADY/BVALID delays (0–5 cycles) with qty=20: data stays correct and VALID/payload stay stable while stalled.
  - Inject SLVERR on one BRESP: `dma_err_o`=1 stays set until the next start, and the transfer completes.
  - A second `dma_en_i` mid-transfer is ignored.
- **Reset mid-operation:** drop `rstn` during WR_W of burst 2. All outputs reach reset values immediately. A new start after release completes normally.
